// File: rtl/sa_pkg.sv
// Shared definitions for the tiled GEMM sequencer.
//   - DEF_* : default parameter values used by the interface and modules
//   - state_e : sequencer FSM states
//   - sat_clip: clamp a 64-bit signed value to a w-bit signed range and
//               report whether clamping happened
package sa_pkg;

  localparam int unsigned DEF_D_W       = 8;
  localparam int unsigned DEF_R_W       = 16;
  localparam int unsigned DEF_ACC_W     = 24;
  localparam int unsigned DEF_SA_R      = 16;
  localparam int unsigned DEF_SA_C      = 16;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_OUT_SHIFT = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_SA,
    OUTPUT,
    DONE
  } state_e;

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int unsigned        w,
                                                  output logic              hit);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi       = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo       = -(64'sd1 <<< (w - 1));
    hit      = 1'b0;
    sat_clip = v;
    if (v > hi) begin
      sat_clip = hi;
      hit      = 1'b1;
    end else if (v < lo) begin
      sat_clip = lo;
      hit      = 1'b1;
    end
  endfunction

endpackage

// File: rtl/sa_gemm_tiler_if.sv
// Bundle of job-control, SA-side and output-tile signals of sa_gemm_tiler.
//   master : the tiler (drives O_* signals, receives I_* signals)
//   slave  : controller / SA_wrapper / downstream side
interface sa_gemm_tiler_if
  import sa_pkg::*;
#(
  parameter int unsigned D_W   = DEF_D_W,
  parameter int unsigned R_W   = DEF_R_W,
  parameter int unsigned SA_R  = DEF_SA_R,
  parameter int unsigned SA_C  = DEF_SA_C,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic                                 I_START;
  logic                                 I_ABORT;
  logic [CNT_W-1:0]                     I_M_TILES;
  logic [CNT_W-1:0]                     I_N_TILES;
  logic [CNT_W-1:0]                     I_K_TILES;
  logic                                 O_BUSY;
  logic                                 O_SA_START;
  logic [CNT_W-1:0]                     O_M_IDX;
  logic [CNT_W-1:0]                     O_N_IDX;
  logic [CNT_W-1:0]                     O_K_IDX;
  logic                                 I_SA_VLD;
  logic [SA_R-1:0][SA_C-1:0][R_W-1:0]   I_SA_RESULT;
  logic                                 O_TILE_VLD;
  logic                                 I_TILE_RDY;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   O_TILE_DATA;
  logic [CNT_W-1:0]                     O_TILE_M_IDX;
  logic [CNT_W-1:0]                     O_TILE_N_IDX;
  logic                                 O_DONE;
  logic                                 O_SAT;

  modport master (
    input  I_START, I_ABORT, I_M_TILES, I_N_TILES, I_K_TILES,
           I_SA_VLD, I_SA_RESULT, I_TILE_RDY,
    output O_BUSY, O_SA_START, O_M_IDX, O_N_IDX, O_K_IDX,
           O_TILE_VLD, O_TILE_DATA, O_TILE_M_IDX, O_TILE_N_IDX, O_DONE, O_SAT
  );

  modport slave (
    output I_START, I_ABORT, I_M_TILES, I_N_TILES, I_K_TILES,
           I_SA_VLD, I_SA_RESULT, I_TILE_RDY,
    input  O_BUSY, O_SA_START, O_M_IDX, O_N_IDX, O_K_IDX,
           O_TILE_VLD, O_TILE_DATA, O_TILE_M_IDX, O_TILE_N_IDX, O_DONE, O_SAT
  );
endinterface

// File: rtl/sa_tile_accum.sv
// SA_R x SA_C signed accumulator array with requantised output path.
//   clk_i/rst_i : clock, async active-high reset (clears the array)
//   add_i       : load (clr_i ? 0 : acc) + sext(res_i), saturated to ACC_W
//   clr_i       : first K partial product, discard previous contents
//   res_i       : SA partial product tile
//   data_o      : sat_D_W(acc >>> OUT_SHIFT) from the registered array
//   acc_sat_o   : the add presented this cycle saturates some element
//   out_sat_o   : some element of data_o is clamped
module sa_tile_accum
  import sa_pkg::*;
#(
  parameter int unsigned D_W       = DEF_D_W,
  parameter int unsigned R_W       = DEF_R_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned SA_R      = DEF_SA_R,
  parameter int unsigned SA_C      = DEF_SA_C,
  parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               add_i,
  input  logic                               clr_i,
  input  logic [SA_R-1:0][SA_C-1:0][R_W-1:0] res_i,
  output logic [SA_R-1:0][SA_C-1:0][D_W-1:0] data_o,
  output logic                               acc_sat_o,
  output logic                               out_sat_o
);
  logic signed [ACC_W-1:0] acc_q [SA_R][SA_C];
  logic signed [ACC_W-1:0] acc_d [SA_R][SA_C];

  always_comb begin
    logic signed [63:0] sum;
    logic signed [63:0] clip;
    logic               hit;
    acc_sat_o = 1'b0;
    out_sat_o = 1'b0;
    data_o    = '0;
    for (int unsigned i = 0; i < SA_R; i++) begin
      for (int unsigned j = 0; j < SA_C; j++) begin
        sum         = (clr_i ? 64'sd0 : 64'(acc_q[i][j])) + 64'($signed(res_i[i][j]));
        clip        = sat_clip(sum, ACC_W, hit);
        acc_d[i][j] = clip[ACC_W-1:0];
        acc_sat_o   = acc_sat_o | hit;
        // >>> on the sign-extended value gives a floor shift
        clip         = sat_clip(64'(acc_q[i][j]) >>> OUT_SHIFT, D_W, hit);
        data_o[i][j] = clip[D_W-1:0];
        out_sat_o    = out_sat_o | hit;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SA_R; i++)
        for (int unsigned j = 0; j < SA_C; j++)
          acc_q[i][j] <= '0;
    end else if (add_i) begin
      for (int unsigned i = 0; i < SA_R; i++)
        for (int unsigned j = 0; j < SA_C; j++)
          acc_q[i][j] <= acc_d[i][j];
    end
  end
endmodule

// File: rtl/sa_gemm_tiler.sv
// Tiled GEMM sequencer: walks m (outer), n, k (inner) tiles, issues one SA
// start per tile product, accumulates K partials, and hands each
// requantised tile downstream on valid/ready.
//   I_CLK, I_ASYN_RST : clock, asynchronous active-high reset
//   bus (master)      : job control, SA start/indices/result, output tile
module sa_gemm_tiler
  import sa_pkg::*;
#(
  parameter int unsigned D_W       = DEF_D_W,
  parameter int unsigned R_W       = DEF_R_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned SA_R      = DEF_SA_R,
  parameter int unsigned SA_C      = DEF_SA_C,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic            I_CLK,
  input  logic            I_ASYN_RST,
  sa_gemm_tiler_if.master bus
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] m_q, n_q, k_q, mt_q, nt_q, kt_q;
  logic             sat_q;
  logic             accept, sa_hit, hs, k_last, n_last, m_last, k_first;
  logic             acc_hit, out_hit;

  always_comb begin
    accept  = (state_q == IDLE) && bus.I_START && !bus.I_ABORT;
    sa_hit  = (state_q == WAIT_SA) && bus.I_SA_VLD && !bus.I_ABORT;
    hs      = (state_q == OUTPUT) && bus.I_TILE_RDY && !bus.I_ABORT;
    k_last  = (k_q == kt_q - ONE);
    n_last  = (n_q == nt_q - ONE);
    m_last  = (m_q == mt_q - ONE);
    k_first = (k_q == '0);
  end

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.I_ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.I_START)
                state_d = (bus.I_M_TILES == '0 || bus.I_N_TILES == '0 ||
                           bus.I_K_TILES == '0) ? DONE : ISSUE;
        ISSUE:   state_d = WAIT_SA;
        WAIT_SA: if (bus.I_SA_VLD) state_d = k_last ? OUTPUT : ISSUE;
        OUTPUT:  if (bus.I_TILE_RDY) state_d = (m_last && n_last) ? DONE : ISSUE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.O_BUSY       = (state_q != IDLE);
    bus.O_SA_START   = (state_q == ISSUE);
    bus.O_TILE_VLD   = (state_q == OUTPUT);
    bus.O_DONE       = (state_q == DONE);
    bus.O_M_IDX      = m_q;
    bus.O_N_IDX      = n_q;
    bus.O_K_IDX      = k_q;
    bus.O_TILE_M_IDX = m_q;
    bus.O_TILE_N_IDX = n_q;
    bus.O_SAT        = sat_q;
  end

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      m_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
      mt_q  <= '0;
      nt_q  <= '0;
      kt_q  <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      mt_q  <= bus.I_M_TILES;
      nt_q  <= bus.I_N_TILES;
      kt_q  <= bus.I_K_TILES;
      m_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      if (sa_hit && !k_last) k_q <= k_q + ONE;
      // Indices stay on the last tile at job end instead of wrapping.
      if (hs) begin
        k_q <= '0;
        if (!(m_last && n_last)) begin
          if (n_last) begin
            n_q <= '0;
            m_q <= m_q + ONE;
          end else begin
            n_q <= n_q + ONE;
          end
        end
      end
      if ((sa_hit && acc_hit) || ((state_q == OUTPUT) && out_hit)) sat_q <= 1'b1;
    end
  end

  sa_tile_accum #(
    .D_W      (D_W),
    .R_W      (R_W),
    .ACC_W    (ACC_W),
    .SA_R     (SA_R),
    .SA_C     (SA_C),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_accum (
    .clk_i    (I_CLK),
    .rst_i    (I_ASYN_RST),
    .add_i    (sa_hit),
    .clr_i    (k_first),
    .res_i    (bus.I_SA_RESULT),
    .data_o   (bus.O_TILE_DATA),
    .acc_sat_o(acc_hit),
    .out_sat_o(out_hit)
  );
endmodule
